// File: rtl/rx32_pkg.sv
// Shared definitions for the rx32 instruction-fetch path: cache geometry and
// the refill FSM state encoding.
package rx32_pkg;

    localparam int ICACHE_NLINES = 16;
    localparam int ICACHE_NWORDS = 4;
    localparam int XLEN          = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REFILL = 2'd1,
        FILLED = 2'd2
    } icache_state_t;

    // Tag width left after removing byte, word-offset and index bits.
    function automatic int icacheTagWidth(input int nLines, input int nWords);
        return XLEN - 2 - $clog2(nLines) - $clog2(nWords);
    endfunction

endpackage

// File: rtl/icache_array.sv
// Tag, data and valid storage for the direct-mapped instruction cache.
// Reads are combinational; writes and valid updates happen on the clock edge.
module icache_array
    import rx32_pkg::*;
#(
    parameter int NLINES = ICACHE_NLINES,
    parameter int NWORDS = ICACHE_NWORDS,
    parameter int TAGW   = icacheTagWidth(ICACHE_NLINES, ICACHE_NWORDS)
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [$clog2(NLINES)-1:0]  rdIndex,
    input  logic [$clog2(NWORDS)-1:0]  rdOffset,
    output logic                       rdValid,
    output logic [TAGW-1:0]            rdTag,
    output logic [XLEN-1:0]            rdWord,
    input  logic                       wrEn,
    input  logic [$clog2(NLINES)-1:0]  wrIndex,
    input  logic [$clog2(NWORDS)-1:0]  wrOffset,
    input  logic [XLEN-1:0]            wrWord,
    input  logic                       fillDone,
    input  logic [TAGW-1:0]            fillTag,
    input  logic                       invEn,
    input  logic [$clog2(NLINES)-1:0]  invIndex,
    input  logic                       flashClr
);

    logic [XLEN-1:0]   dataMem [NLINES][NWORDS];
    logic [TAGW-1:0]   tagMem  [NLINES];
    logic [NLINES-1:0] valid;

    assign rdValid = valid[rdIndex];
    assign rdTag   = tagMem[rdIndex];
    assign rdWord  = dataMem[rdIndex][rdOffset];

    // A flush beats any same-cycle line install so a flushed line never turns valid.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid <= '0;
        end else if (flashClr) begin
            valid <= '0;
        end else if (fillDone) begin
            valid[wrIndex] <= 1'b1;
        end else if (invEn) begin
            valid[invIndex] <= 1'b0;
        end
    end

    // NOTE: tag and data arrays carry no reset; valid alone guards them, and
    // leaving them unreset lets synthesis map them onto plain RAM.
    always_ff @(posedge clk) begin
        if (wrEn) begin
            dataMem[wrIndex][wrOffset] <= wrWord;
        end
        if (fillDone) begin
            tagMem[wrIndex] <= fillTag;
        end
    end

endmodule

// File: rtl/instr_cache.sv
// Direct-mapped instruction cache: zero-latency hits, in-order line refill
// over a single-word request/ack memory port, with flush and refill abort.
module instr_cache
    import rx32_pkg::*;
#(
    parameter int NLINES = ICACHE_NLINES,
    parameter int NWORDS = ICACHE_NWORDS
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] PCF,
    input  logic        flush,
    output logic [31:0] instrF,
    output logic        stallF,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
);

    localparam int OFFW = $clog2(NWORDS);
    localparam int IDXW = $clog2(NLINES);
    localparam int TAGW = icacheTagWidth(NLINES, NWORDS);
    localparam logic [OFFW-1:0] LAST_BEAT = OFFW'(NWORDS - 1);

    icache_state_t   state;
    logic [OFFW-1:0] beat;
    logic [OFFW-1:0] nextBeat;
    logic            abort;
    logic [TAGW-1:0] fillTag;
    logic [IDXW-1:0] fillIndex;

    logic [OFFW-1:0] pcOffset;
    logic [IDXW-1:0] pcIndex;
    logic [TAGW-1:0] pcTag;
    logic            unusedPcBits;

    logic            rdValid;
    logic [TAGW-1:0] rdTag;
    logic [31:0]     rdWord;

    logic hit;
    logic missStart;
    logic ackBeat;
    logic abortNow;
    logic lastAck;
    logic fillDone;

    assign pcOffset     = PCF[OFFW+1:2];
    assign pcIndex      = PCF[OFFW+2 +: IDXW];
    assign pcTag        = PCF[31 -: TAGW];
    // Byte-within-word bits carry no information for word fetches.
    assign unusedPcBits = ^PCF[1:0];
    assign nextBeat     = beat + 1'b1;

    // NOTE: every signal gets a default first so no path through this block
    // can leave one unassigned and infer a latch.
    always_comb begin
        hit       = 1'b0;
        missStart = 1'b0;
        ackBeat   = 1'b0;
        abortNow  = abort || flush;
        lastAck   = 1'b0;
        fillDone  = 1'b0;
        stallF    = 1'b1;
        instrF    = '0;

        hit = rdValid && (rdTag == pcTag);
        if (state == IDLE) begin
            missStart = !flush && !hit;
            stallF    = flush || !hit;
        end
        if (state == REFILL) begin
            ackBeat  = mem_req && mem_ack;
            lastAck  = ackBeat && (beat == LAST_BEAT);
            fillDone = lastAck && !abortNow;
        end
        if (!stallF) begin
            instrF = rdWord;
        end
    end

    icache_array #(
        .NLINES (NLINES),
        .NWORDS (NWORDS),
        .TAGW   (TAGW)
    ) u_array (
        .clk      (clk),
        .reset    (reset),
        .rdIndex  (pcIndex),
        .rdOffset (pcOffset),
        .rdValid  (rdValid),
        .rdTag    (rdTag),
        .rdWord   (rdWord),
        .wrEn     (ackBeat),
        .wrIndex  (fillIndex),
        .wrOffset (beat),
        .wrWord   (mem_rdata),
        .fillDone (fillDone),
        .fillTag  (fillTag),
        .invEn    (missStart),
        .invIndex (pcIndex),
        .flashClr (flush)
    );

    // NOTE: state registers use non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            beat      <= '0;
            abort     <= 1'b0;
            fillTag   <= '0;
            fillIndex <= '0;
            mem_req   <= 1'b0;
            mem_addr  <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (missStart) begin
                        fillTag   <= pcTag;
                        fillIndex <= pcIndex;
                        beat      <= '0;
                        abort     <= 1'b0;
                        mem_req   <= 1'b1;
                        mem_addr  <= {pcTag, pcIndex, {OFFW{1'b0}}, 2'b00};
                        state     <= REFILL;
                    end
                end
                REFILL: begin
                    if (flush) begin
                        abort <= 1'b1;
                    end
                    // An aborted refill still finishes the beat in flight.
                    if (ackBeat) begin
                        if (abortNow || lastAck) begin
                            mem_req <= 1'b0;
                            abort   <= 1'b0;
                            beat    <= '0;
                            state   <= abortNow ? IDLE : FILLED;
                        end else begin
                            beat     <= nextBeat;
                            mem_addr <= {fillTag, fillIndex, nextBeat, 2'b00};
                        end
                    end
                end
                FILLED: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_cache.sv
// Directed scoreboard bench for instr_cache: expected fetch addresses are
// queued when a miss is provoked and checked on every memory ack.
module tb_instr_cache;

    logic        clk;
    logic        reset;
    logic [31:0] PCF;
    logic        flush;
    logic [31:0] instrF;
    logic        stallF;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    int          vectors     = 0;
    int          miscompares = 0;
    logic [31:0] expQ[$];
    int          ackWait  = 1;
    int          waitCnt  = 0;
    int          ackCount = 0;
    logic        prevReq  = 1'b0;
    logic        prevAck  = 1'b0;
    logic [31:0] prevAddr = '0;

    instr_cache dut (
        .clk       (clk),
        .reset     (reset),
        .PCF       (PCF),
        .flush     (flush),
        .instrF    (instrF),
        .stallF    (stallF),
        .mem_req   (mem_req),
        .mem_addr  (mem_addr),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    function automatic logic [31:0] memWord(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h0BAD_F00D;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h, required %h", tag, obs, exp);
        end
    endtask

    task automatic pushLine(input logic [31:0] base);
        for (int i = 0; i < 4; i++) expQ.push_back(base + 32'(4 * i));
    endtask

    task automatic resetModel();
        waitCnt = 0;
        prevReq = 1'b0;
        prevAck = 1'b0;
        prevAddr = '0;
    endtask

    // One clock: at the falling edge, check request stability and play the
    // memory (ack after ackWait idle cycles with the request held).
    task automatic cycle();
        logic ack;
        @(negedge clk);
        if (prevReq && !prevAck) begin
            check("reqHold", {31'd0, mem_req}, 32'd1);
            check("addrHold", mem_addr, prevAddr);
        end
        ack = 1'b0;
        if (mem_req) begin
            if (waitCnt >= ackWait) begin
                ack = 1'b1;
                waitCnt = 0;
                ackCount++;
                vectors++;
                assert (expQ.size() != 0) else begin
                    miscompares++;
                    $error("FAIL addrQ: observed unexpected request %h, required none", mem_addr);
                end
                if (expQ.size() != 0) check("memAddr", mem_addr, expQ.pop_front());
            end else begin
                waitCnt++;
            end
        end else begin
            waitCnt = 0;
        end
        mem_ack   = ack;
        mem_rdata = ack ? memWord(mem_addr) : 32'hDEAD_BEEF;
        prevReq   = mem_req;
        prevAddr  = mem_addr;
        prevAck   = ack;
    endtask

    // Counts stalled cycles starting with the current one, then checks the hit.
    task automatic runUntilHit(input int expStall, input string tag, input logic [31:0] pc);
        int n = 0;
        #1;
        while (stallF !== 1'b0 && n < 200) begin
            n++;
            cycle();
            #1;
        end
        check({tag, "_stall"}, 32'(n), 32'(expStall));
        check({tag, "_instr"}, instrF, memWord({pc[31:2], 2'b00}));
        check({tag, "_req"}, {31'd0, mem_req}, 32'd0);
    endtask

    initial begin
        int start;
        int guard;

        reset = 1'b1;
        PCF = 32'h0;
        flush = 1'b0;
        mem_ack = 1'b0;
        mem_rdata = '0;
        repeat (2) @(negedge clk);
        check("rstReq", {31'd0, mem_req}, 32'd0);
        check("rstAddr", mem_addr, 32'd0);
        check("rstStall", {31'd0, stallF}, 32'd1);
        check("rstInstr", instrF, 32'd0);

        // Cold miss with single-cycle ack wait.
        reset = 1'b0;
        ackWait = 1;
        PCF = 32'h40;
        pushLine(32'h40);
        runUntilHit(10, "cold", 32'h40);

        // Back-to-back hits in the loaded line.
        cycle();
        PCF = 32'h44;
        #1;
        check("hit44_stall", {31'd0, stallF}, 32'd0);
        check("hit44_instr", instrF, memWord(32'h44));
        check("hit44_req", {31'd0, mem_req}, 32'd0);
        cycle();
        PCF = 32'h4C;
        #1;
        check("hit4C_stall", {31'd0, stallF}, 32'd0);
        check("hit4C_instr", instrF, memWord(32'h4C));
        check("hit4C_req", {31'd0, mem_req}, 32'd0);

        // Conflict on index 4: new tag evicts, old tag then misses again.
        cycle();
        PCF = 32'h140;
        pushLine(32'h140);
        runUntilHit(10, "conflict", 32'h140);
        cycle();
        PCF = 32'h40;
        #1;
        check("conflictMiss", {31'd0, stallF}, 32'd1);
        pushLine(32'h40);
        runUntilHit(10, "reload", 32'h40);

        // Flush in the second refill cycle: beat 0 completes, nothing more.
        cycle();
        ackWait = 3;
        PCF = 32'h80;
        expQ.push_back(32'h80);
        #1;
        check("abortMiss", {31'd0, stallF}, 32'd1);
        cycle();
        cycle();
        flush = 1'b1;
        cycle();
        flush = 1'b0;
        cycle();
        check("abortAck", {31'd0, mem_ack}, 32'd1);
        cycle();
        check("abortNoReq", {31'd0, mem_req}, 32'd0);
        check("abortQEmpty", 32'(expQ.size()), 32'd0);
        pushLine(32'h80);
        runUntilHit(18, "refetch", 32'h80);

        // Flush coincident with the final ack leaves the line invalid.
        cycle();
        ackWait = 1;
        PCF = 32'hC0;
        pushLine(32'hC0);
        start = ackCount;
        guard = 0;
        #1;
        while (ackCount < start + 4 && guard < 50) begin
            cycle();
            guard++;
        end
        check("finalAckSeen", 32'(ackCount - start), 32'd4);
        flush = 1'b1;
        cycle();
        flush = 1'b0;
        #1;
        check("finalFlushInvalid", {31'd0, stallF}, 32'd1);
        pushLine(32'hC0);
        runUntilHit(10, "finalFlushRefill", 32'hC0);

        // Stretched acks: three wait cycles per beat.
        cycle();
        ackWait = 3;
        PCF = 32'h200;
        pushLine(32'h200);
        runUntilHit(18, "stretch", 32'h200);

        // Reset mid-refill, then a stray ack with no request outstanding.
        cycle();
        ackWait = 1;
        PCF = 32'h300;
        pushLine(32'h300);
        #1;
        cycle();
        cycle();
        cycle();
        check("midReqBefore", {31'd0, mem_req}, 32'd1);
        reset = 1'b1;
        #1;
        check("midRstReq", {31'd0, mem_req}, 32'd0);
        check("midRstAddr", mem_addr, 32'd0);
        check("midRstInstr", instrF, 32'd0);
        expQ.delete();
        resetModel();
        #1;
        reset = 1'b0;
        flush = 1'b1;
        mem_ack = 1'b1;
        mem_rdata = 32'hBAD0_BAD0;
        @(posedge clk);
        #1;
        check("strayReq", {31'd0, mem_req}, 32'd0);
        @(negedge clk);
        mem_ack = 1'b0;
        flush = 1'b0;
        resetModel();
        #1;
        check("strayNoValid", {31'd0, stallF}, 32'd1);
        pushLine(32'h300);
        runUntilHit(10, "postReset", 32'h300);
        PCF = 32'h308;
        #1;
        check("postReset308", instrF, memWord(32'h308));

        check("queueDrained", 32'(expQ.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
